ascon_ctrl: RTL

ASCON_CTRL -- requirements
Module: ascon_ctrl

---
 rtl/ascon_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: sequencing controller for an Ascon-style AEAD operation built
// around an external permutation engine.
//
// State | meaning
// IDLE  | waiting for a start edge (only honoured once a key has been written)
// INIT  | initial 12-round permutation in flight
// ABS_HI| waiting for the high 32-bit word of the current 64-bit block
// ABS_LO| waiting for the low 32-bit word of the current 64-bit block
// PERM_B| 6-round permutation between message blocks in flight
// FINAL | 12-round finalisation permutation in flight
// TAG   | decrypt only: comparing four received tag words against the tag
// DONE  | one-cycle completion state, returns to IDLE
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   key_i, key_valid_i       128-bit key and its written strobe
//   nonce_i                  128-bit nonce, sampled at start
//   data_in_i/_valid_i       32-bit input word stream
//   data_out_o/_valid_o      32-bit output word stream (one-cycle strobe)
//   start_enc_i/start_dec_i  level requests, acted on at their rising edge
//   busy_o, done_o, auth_o   status; tag_o holds the last encryption tag
//   perm_*                   request/response handshake to the permutation
module ascon_ctrl #(
  parameter int unsigned MSG_BLOCKS = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [127:0] key_i,
  input  logic         key_valid_i,
  input  logic [127:0] nonce_i,
  input  logic [31:0]  data_in_i,
  input  logic         data_in_valid_i,
  output logic [31:0]  data_out_o,
  output logic         data_out_valid_o,
  input  logic         start_enc_i,
  input  logic         start_dec_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         auth_o,
  output logic [127:0] tag_o,
  output logic         perm_start_o,
  output logic [3:0]   perm_rounds_o,
  output logic [319:0] perm_state_o,
  input  logic [319:0] perm_state_i,
  input  logic         perm_done_i
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_ABS_HI = 3'd2;
  localparam logic [2:0] ST_ABS_LO = 3'd3;
  localparam logic [2:0] ST_PERM_B = 3'd4;
  localparam logic [2:0] ST_FINAL  = 3'd5;
  localparam logic [2:0] ST_TAG    = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  localparam logic [63:0] IV       = 64'h80400c0600000000;
  localparam logic [7:0]  LAST_BLK = 8'(MSG_BLOCKS - 1);

  logic [2:0]   state_q;
  logic [319:0] s_q;
  logic [7:0]   blk_cnt_q;
  logic [127:0] key_q;
  logic         key_loaded_q;
  logic         enc_prev_q;
  logic         dec_prev_q;
  logic         dec_mode_q;
  logic [1:0]   tag_idx_q;
  logic         tag_ok_q;

  logic         enc_rise;
  logic         dec_rise;
  logic [63:0]  khi;
  logic [63:0]  klo;
  logic [31:0]  x0_half;
  logic [31:0]  out_word;
  logic [31:0]  new_half;
  logic [319:0] s_abs;
  logic [319:0] s_fin;
  logic [319:0] s_init_done;
  logic [127:0] tag_calc;
  logic [127:0] tag_perm;
  logic [31:0]  tag_word;
  logic         tag_match;

  assign enc_rise = start_enc_i & ~enc_prev_q;
  assign dec_rise = start_dec_i & ~dec_prev_q;
  assign khi      = key_q[127:64];
  assign klo      = key_q[63:0];

  // The state register feeds the permutation directly; it is only written on
  // the cycle that issues a request or on perm_done_i, so it stays stable
  // for the whole request.
  assign perm_state_o = s_q;
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Encrypt chains the ciphertext into x0, decrypt chains the received word.
  assign x0_half  = (state_q == ST_ABS_HI) ? s_q[319:288] : s_q[287:256];
  assign out_word = x0_half ^ data_in_i;
  assign new_half = dec_mode_q ? data_in_i : out_word;
  assign s_abs    = (state_q == ST_ABS_HI) ? {new_half, s_q[287:0]}
                                           : {s_q[319:288], new_half, s_q[255:0]};
  assign s_fin    = s_abs ^ {64'h8000000000000000, khi, klo, 128'd0};

  // Key mixed into x3/x4, then the domain-separation bit since there is no AD.
  assign s_init_done = perm_state_i ^ {192'd0, khi, klo} ^ 320'd1;

  assign tag_calc = {s_q[127:64] ^ khi, s_q[63:0] ^ klo};
  assign tag_perm = {perm_state_i[127:64] ^ khi, perm_state_i[63:0] ^ klo};

  always_comb begin
    tag_word = tag_calc[127:96];
    case (tag_idx_q)
      2'd1:    tag_word = tag_calc[95:64];
      2'd2:    tag_word = tag_calc[63:32];
      2'd3:    tag_word = tag_calc[31:0];
      default: tag_word = tag_calc[127:96];
    endcase
  end

  assign tag_match = (data_in_i == tag_word);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      s_q              <= '0;
      blk_cnt_q        <= '0;
      key_q            <= '0;
      key_loaded_q     <= 1'b0;
      enc_prev_q       <= 1'b0;
      dec_prev_q       <= 1'b0;
      dec_mode_q       <= 1'b0;
      tag_idx_q        <= '0;
      tag_ok_q         <= 1'b0;
      data_out_o       <= '0;
      data_out_valid_o <= 1'b0;
      done_o           <= 1'b0;
      auth_o           <= 1'b0;
      tag_o            <= '0;
      perm_start_o     <= 1'b0;
      perm_rounds_o    <= '0;
    end else begin
      enc_prev_q       <= start_enc_i;
      dec_prev_q       <= start_dec_i;
      perm_start_o     <= 1'b0;
      data_out_valid_o <= 1'b0;
      if (key_valid_i) key_loaded_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (key_loaded_q && (enc_rise || dec_rise)) begin
            key_q         <= key_i;
            dec_mode_q    <= ~enc_rise;
            done_o        <= 1'b0;
            auth_o        <= 1'b0;
            blk_cnt_q     <= '0;
            tag_idx_q     <= '0;
            tag_ok_q      <= 1'b1;
            s_q           <= {IV, key_i, nonce_i};
            perm_start_o  <= 1'b1;
            perm_rounds_o <= 4'd12;
            state_q       <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (perm_done_i) begin
            s_q     <= s_init_done;
            state_q <= ST_ABS_HI;
          end
        end
        ST_ABS_HI: begin
          if (data_in_valid_i) begin
            data_out_o       <= out_word;
            data_out_valid_o <= 1'b1;
            s_q              <= s_abs;
            state_q          <= ST_ABS_LO;
          end
        end
        ST_ABS_LO: begin
          if (data_in_valid_i) begin
            data_out_o       <= out_word;
            data_out_valid_o <= 1'b1;
            perm_start_o     <= 1'b1;
            if (blk_cnt_q < LAST_BLK) begin
              s_q           <= s_abs;
              perm_rounds_o <= 4'd6;
              state_q       <= ST_PERM_B;
            end else begin
              s_q           <= s_fin;
              perm_rounds_o <= 4'd12;
              state_q       <= ST_FINAL;
            end
          end
        end
        ST_PERM_B: begin
          if (perm_done_i) begin
            s_q       <= perm_state_i;
            blk_cnt_q <= blk_cnt_q + 8'd1;
            state_q   <= ST_ABS_HI;
          end
        end
        ST_FINAL: begin
          if (perm_done_i) begin
            s_q <= perm_state_i;
            if (dec_mode_q) begin
              state_q <= ST_TAG;
            end else begin
              tag_o   <= tag_perm;
              auth_o  <= 1'b0;
              done_o  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_TAG: begin
          if (data_in_valid_i) begin
            tag_ok_q  <= tag_ok_q & tag_match;
            tag_idx_q <= tag_idx_q + 2'd1;
            if (tag_idx_q == 2'd3) begin
              auth_o  <= tag_ok_q & tag_match;
              done_o  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
